// File: rtl/comparator.sv
`default_nettype none
// ============================================================================
//  Module   : comparator
//  Purpose  : Registered magnitude comparator. Compares two WIDTH-bit operands
//             as unsigned or two's-complement (chosen per transaction) and
//             presents one-hot GT/LT/EQ flags plus |A-B| one cycle later.
//  Ports    : clk, rst (sync, active-high)
//             in_valid, signed_mode, a, b        -- transaction inputs
//             out_valid, a_grt_b, a_less_b,
//             a_eq_b, abs_diff                   -- registered result
//             cnt_clr, gt_cnt, lt_cnt, eq_cnt    -- only with
//                                                   COMPARATOR_STATS_EN
//  Options  : `define COMPARATOR_STATS_EN adds saturating GT/LT/EQ event
//             counters of CNT_W bits with a synchronous clear.
//  Revision : 1.0  initial release
// ============================================================================
module comparator #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef COMPARATOR_STATS_EN
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] lt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
`endif
    output logic             out_valid,
    output logic             a_grt_b,
    output logic             a_less_b,
    output logic             a_eq_b,
    output logic [WIDTH-1:0] abs_diff
);

    // Elaboration-time guard on the supported parameter range.
    if (WIDTH < 2 || WIDTH > 32 || CNT_W < 1) begin : g_param_check
        $error("comparator: unsupported WIDTH or CNT_W");
    end

    // ------------------------------------------------------------------
    // Compare: widen both operands by one bit (sign- or zero-extended by
    // mode) so a single signed compare covers both interpretations.
    // ------------------------------------------------------------------
    logic signed [WIDTH:0] a_ext;
    logic signed [WIDTH:0] b_ext;
    logic                  cmp_gt;
    logic                  cmp_lt;
    logic                  cmp_eq;
    logic [WIDTH-1:0]      cmp_diff;

    always_comb begin
        a_ext  = {signed_mode & a[WIDTH-1], a};
        b_ext  = {signed_mode & b[WIDTH-1], b};
        cmp_gt = (a_ext > b_ext);
        cmp_lt = (a_ext < b_ext);
        cmp_eq = (a == b);
        // (larger - smaller) truncated to WIDTH bits equals the WIDTH-bit
        // modular difference, so the extra bit never needs to be formed.
        cmp_diff = cmp_gt ? (a - b) : (b - a);
    end

    // ------------------------------------------------------------------
    // Result registers: flags and difference hold while idle.
    // ------------------------------------------------------------------
    logic             out_valid_d, out_valid_q;
    logic             gt_d, gt_q;
    logic             lt_d, lt_q;
    logic             eq_d, eq_q;
    logic [WIDTH-1:0] diff_d, diff_q;

    always_comb begin
        out_valid_d = in_valid;
        gt_d        = gt_q;
        lt_d        = lt_q;
        eq_d        = eq_q;
        diff_d      = diff_q;
        if (in_valid) begin
            gt_d   = cmp_gt;
            lt_d   = cmp_lt;
            eq_d   = cmp_eq;
            diff_d = cmp_diff;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            gt_q        <= 1'b0;
            lt_q        <= 1'b0;
            eq_q        <= 1'b0;
            diff_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            gt_q        <= gt_d;
            lt_q        <= lt_d;
            eq_q        <= eq_d;
            diff_q      <= diff_d;
        end
    end

    assign out_valid = out_valid_q;
    assign a_grt_b   = gt_q;
    assign a_less_b  = lt_q;
    assign a_eq_b    = eq_q;
    assign abs_diff  = diff_q;

`ifdef COMPARATOR_STATS_EN
    // ------------------------------------------------------------------
    // Saturating event counters; clear takes priority over counting.
    // ------------------------------------------------------------------
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] gt_cnt_d, gt_cnt_q;
    logic [CNT_W-1:0] lt_cnt_d, lt_cnt_q;
    logic [CNT_W-1:0] eq_cnt_d, eq_cnt_q;

    always_comb begin
        gt_cnt_d = gt_cnt_q;
        lt_cnt_d = lt_cnt_q;
        eq_cnt_d = eq_cnt_q;
        if (cnt_clr) begin
            gt_cnt_d = '0;
            lt_cnt_d = '0;
            eq_cnt_d = '0;
        end else if (in_valid) begin
            if (cmp_gt && gt_cnt_q != CNT_MAX) gt_cnt_d = gt_cnt_q + CNT_ONE;
            if (cmp_lt && lt_cnt_q != CNT_MAX) lt_cnt_d = lt_cnt_q + CNT_ONE;
            if (cmp_eq && eq_cnt_q != CNT_MAX) eq_cnt_d = eq_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gt_cnt_q <= '0;
            lt_cnt_q <= '0;
            eq_cnt_q <= '0;
        end else begin
            gt_cnt_q <= gt_cnt_d;
            lt_cnt_q <= lt_cnt_d;
            eq_cnt_q <= eq_cnt_d;
        end
    end

    assign gt_cnt = gt_cnt_q;
    assign lt_cnt = lt_cnt_q;
    assign eq_cnt = eq_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_comparator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_comparator
//  Purpose  : Self-checking bench for comparator. Directed and random
//             transactions are compared against an integer reference model.
//  Options  : honours COMPARATOR_STATS_EN (counters built with CNT_W=2).
//  Revision : 1.0  initial release
// ============================================================================
module tb_comparator;

    localparam int WIDTH = 4;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             signed_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             a_grt_b;
    logic             a_less_b;
    logic             a_eq_b;
    logic [WIDTH-1:0] abs_diff;
`ifdef COMPARATOR_STATS_EN
    logic             cnt_clr;
    logic [CNT_W-1:0] gt_cnt;
    logic [CNT_W-1:0] lt_cnt;
    logic [CNT_W-1:0] eq_cnt;
`endif

    comparator #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
`ifdef COMPARATOR_STATS_EN
        .cnt_clr     (cnt_clr),
        .gt_cnt      (gt_cnt),
        .lt_cnt      (lt_cnt),
        .eq_cnt      (eq_cnt),
`endif
        .out_valid   (out_valid),
        .a_grt_b     (a_grt_b),
        .a_less_b    (a_less_b),
        .a_eq_b      (a_eq_b),
        .abs_diff    (abs_diff)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Expected state kept by the reference model.
    int exp_gt   = 0;
    int exp_lt   = 0;
    int exp_eq   = 0;
    int exp_diff = 0;
    int m_gt_cnt = 0;
    int m_lt_cnt = 0;
    int m_eq_cnt = 0;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Operand value as a plain integer under the chosen interpretation.
    function automatic int to_int(input int raw, input bit sgn);
        if (sgn && raw >= (1 << (WIDTH - 1))) return raw - (1 << WIDTH);
        return raw;
    endfunction

    function automatic int sat_inc(input int v);
        return (v < (1 << CNT_W) - 1) ? v + 1 : v;
    endfunction

    task automatic check_flags(input string tag);
        check({tag, ".gt"},   int'(a_grt_b),  exp_gt);
        check({tag, ".lt"},   int'(a_less_b), exp_lt);
        check({tag, ".eq"},   int'(a_eq_b),   exp_eq);
        check({tag, ".diff"}, int'(abs_diff), exp_diff);
    endtask

    task automatic check_counters(input string tag);
`ifdef COMPARATOR_STATS_EN
        check({tag, ".gt_cnt"}, int'(gt_cnt), m_gt_cnt);
        check({tag, ".lt_cnt"}, int'(lt_cnt), m_lt_cnt);
        check({tag, ".eq_cnt"}, int'(eq_cnt), m_eq_cnt);
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    // One accepted transaction: drive, clock, then check one cycle later.
    task automatic send(input string tag, input bit sm, input int av, input int bv,
                        input bit clr);
        int x, y;
        in_valid    = 1'b1;
        signed_mode = sm;
        a           = WIDTH'(av);
        b           = WIDTH'(bv);
`ifdef COMPARATOR_STATS_EN
        cnt_clr     = clr;
`endif
        x        = to_int(av, sm);
        y        = to_int(bv, sm);
        exp_gt   = (x > y)  ? 1 : 0;
        exp_lt   = (x < y)  ? 1 : 0;
        exp_eq   = (x == y) ? 1 : 0;
        exp_diff = ((x > y) ? x - y : y - x) % (1 << WIDTH);
        if (clr) begin
            m_gt_cnt = 0;
            m_lt_cnt = 0;
            m_eq_cnt = 0;
        end else begin
            if (exp_gt == 1) m_gt_cnt = sat_inc(m_gt_cnt);
            if (exp_lt == 1) m_lt_cnt = sat_inc(m_lt_cnt);
            if (exp_eq == 1) m_eq_cnt = sat_inc(m_eq_cnt);
        end
        @(posedge clk);
        #1;
        check({tag, ".valid"}, int'(out_valid), 1);
        check({tag, ".onehot"}, int'(a_grt_b) + int'(a_less_b) + int'(a_eq_b), 1);
        check_flags(tag);
        check_counters(tag);
`ifdef COMPARATOR_STATS_EN
        cnt_clr = 1'b0;
`endif
    endtask

    task automatic idle(input string tag);
        in_valid = 1'b0;
        a        = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
        b        = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
        @(posedge clk);
        #1;
        check({tag, ".valid"}, int'(out_valid), 0);
        check_flags(tag);
        check_counters(tag);
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b1;
        signed_mode = 1'b0;
        a           = 4'h3;
        b           = 4'h3;
`ifdef COMPARATOR_STATS_EN
        cnt_clr     = 1'b0;
`endif
        // Reset with a pending transaction: it must be dropped.
        repeat (2) @(posedge clk);
        #1;
        check("rst.valid", int'(out_valid), 0);
        check_flags("rst");
        check_counters("rst");
        rst = 1'b0;

        // Unsigned directed set.
        send("u_gt", 1'b0, 'h9, 'h4, 1'b0);
        check("u_gt.diff5", int'(abs_diff), 5);
        send("u_lt", 1'b0, 'h2, 'hD, 1'b0);
        check("u_lt.diffB", int'(abs_diff), 'hB);
        send("u_eq", 1'b0, 'h7, 'h7, 1'b0);

        // Signed compare, including the extreme-magnitude difference.
        send("s_lt", 1'b1, 'h8, 'h7, 1'b0);
        check("s_lt.lt", int'(a_less_b), 1);
        check("s_lt.diffF", int'(abs_diff), 'hF);
        send("s_gt", 1'b1, 'hF, 'hE, 1'b0);
        send("u_same", 1'b0, 'h8, 'h7, 1'b0);
        check("u_same.gt", int'(a_grt_b), 1);

        // Streaming, then hold on idle.
        for (int i = 0; i < 5; i++)
            send("stream", 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 15)), 1'b0);
        idle("hold");
        idle("hold2");

        // Random mix of transactions and idle cycles.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) idle("rnd_idle");
            else send("rnd", 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 15)), 1'b0);
        end

`ifdef COMPARATOR_STATS_EN
        // Clear together with a transaction: clear wins.
        send("clr", 1'b0, 'h9, 'h1, 1'b1);
        send("seq_gt1", 1'b0, 'h5, 'h1, 1'b0);
        send("seq_gt2", 1'b0, 'hA, 'h2, 1'b0);
        send("seq_lt",  1'b0, 'h1, 'h5, 1'b0);
        send("seq_eq",  1'b0, 'h6, 'h6, 1'b0);
        check("seq.gt2", int'(gt_cnt), 2);
        check("seq.lt1", int'(lt_cnt), 1);
        check("seq.eq1", int'(eq_cnt), 1);
        send("clr2", 1'b1, 'h2, 'h2, 1'b1);
        for (int i = 0; i < 4; i++) send("sat", 1'b0, 'hC, 'h3, 1'b0);
        check("sat.gt3", int'(gt_cnt), 3);
        idle("sat_hold");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
